// File: rtl/cde_jtag_master.sv
// JTAG initiator: runs one TAP reset, IR scan or DR scan per request, generating
// TCK/TMS/TDI/TRST_N from clk and returning the captured TDO bits right-justified.
module cde_jtag_master #(
  parameter int DIVCNT     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [LEN_W-1:0]      shift_len,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tclk,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo,
  output logic                  trst_n
);

  localparam int CNT_W = $clog2(2 * DIVCNT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIVCNT - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DIVCNT - 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_SHIFT, S_TRL, S_RST, S_NOP, S_DONE
  } state_t;

  state_t                state_q, state_d, nxt_state;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      idx_q, idx_d, nxt_idx;
  logic                  ir_q, ir_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  tclk_q, tclk_d;
  logic                  tms_q, tms_d;
  logic                  tdi_q, tdi_d;
  logic                  trst_n_q, trst_n_d;
  logic                  tlr_q, tlr_d;
  logic                  step;
  logic                  len_ok;
  logic [DATA_WIDTH-1:0] shifted;

  assign len_ok = (shift_len != '0) && (shift_len <= LEN_W'(DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ir_q       <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      tclk_q     <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      trst_n_q   <= 1'b0;
      tlr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ir_q       <= ir_d;
      len_q      <= len_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      tclk_q     <= tclk_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      trst_n_q   <= trst_n_d;
      tlr_q      <= tlr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ir_d       = ir_q;
    len_d      = len_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    tclk_d     = tclk_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    trst_n_d   = trst_n_q;
    tlr_d      = tlr_q;
    nxt_state  = state_q;
    nxt_idx    = idx_q;
    step       = 1'b0;
    shifted    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d  = S_IDLE;
        tclk_d   = 1'b0;
        tdi_d    = 1'b0;
        tms_d    = tlr_q;
        trst_n_d = 1'b1;
        if (start) begin
          ir_d   = cmd[0];
          len_d  = shift_len;
          data_d = data_in;
          if (cmd == 2'b10) begin
            nxt_state = S_RST;
            nxt_idx   = '0;
            step      = 1'b1;
          end else if (!cmd[1] && len_ok) begin
            nxt_state = tlr_q ? S_PRE : S_HDR;
            nxt_idx   = '0;
            step      = 1'b1;
          end else begin
            state_d = S_NOP;
          end
        end
      end

      S_NOP: state_d = S_DONE;

      default: begin
        cnt_d = cnt_q + CNT_W'(1);
        // TDO is captured on the clk edge that raises TCK, before the TAP shifts.
        if (cnt_q == HALF_M1) begin
          tclk_d = 1'b1;
          if (state_q == S_SHIFT) begin
            data_out_d = (idx_q == '0) ? '0 : data_out_q;
            if (tdo) data_out_d = data_out_d | (ONE << idx_q);
          end
        end
        if (cnt_q == LAST) begin
          tclk_d  = 1'b0;
          step    = 1'b1;
          nxt_idx = idx_q + LEN_W'(1);
          case (state_q)
            S_PRE: begin
              nxt_state = S_HDR;
              nxt_idx   = '0;
            end
            S_HDR: begin
              if (idx_q == (ir_q ? LEN_W'(3) : LEN_W'(2))) begin
                nxt_state = S_SHIFT;
                nxt_idx   = '0;
              end
            end
            S_SHIFT: begin
              if (idx_q == len_q - LEN_W'(1)) begin
                nxt_state = S_TRL;
                nxt_idx   = '0;
              end
            end
            S_TRL: if (idx_q == LEN_W'(1)) nxt_state = S_DONE;
            S_RST: if (idx_q == LEN_W'(5)) nxt_state = S_DONE;
            default: nxt_state = S_DONE;
          endcase
        end
      end
    endcase

    // Every period boundary loads the TMS/TDI/TRST_N levels for the next period.
    if (step) begin
      state_d  = nxt_state;
      idx_d    = nxt_idx;
      cnt_d    = '0;
      tdi_d    = 1'b0;
      trst_n_d = 1'b1;
      shifted  = data_d >> nxt_idx;
      case (nxt_state)
        S_PRE:   tms_d = 1'b0;
        S_HDR:   tms_d = (nxt_idx == '0) || (ir_d && nxt_idx == LEN_W'(1));
        S_SHIFT: begin
          tms_d = (nxt_idx == len_d - LEN_W'(1));
          tdi_d = shifted[0];
        end
        S_TRL:   tms_d = (nxt_idx == '0);
        S_RST: begin
          tms_d    = (nxt_idx != LEN_W'(5));
          trst_n_d = (nxt_idx == LEN_W'(5));
        end
        default: begin
          tlr_d = 1'b0;
          tms_d = 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign data_out = data_out_q;
  assign tclk     = tclk_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;
  assign trst_n   = trst_n_q;

endmodule

// File: tb/tb_cde_jtag_master.sv
// Scoreboard bench for cde_jtag_master: predicted per-TCK TMS/TDI/TRST_N sequences,
// captured data and done timing are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_cde_jtag_master;

  localparam int DIVCNT = 4;
  localparam int DW     = 32;
  localparam int LW     = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [LW-1:0] shift_len = '0;
  logic [DW-1:0] data_in = '0;
  logic          busy, done;
  logic [DW-1:0] data_out;
  logic          tclk, tms, tdi, trst_n;
  logic          tdo = 1'b0;

  always #5 clk = ~clk;

  cde_jtag_master #(.DIVCNT(DIVCNT), .DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .shift_len(shift_len),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out), .tclk(tclk),
    .tms(tms), .tdi(tdi), .tdo(tdo), .trst_n(trst_n)
  );

  typedef struct {
    int            ntck;
    logic [63:0]   tms;
    logic [63:0]   tdi;
    logic [63:0]   trst;
    logic [63:0]   pat;
    logic [DW-1:0] dout;
    int unsigned   due;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int unsigned   cyc = 0;
  logic          tlr_m = 1'b1;
  logic [DW-1:0] dout_m = '0;
  int            tck_cnt = 0;
  logic [63:0]   cap_tms = '0, cap_tdi = '0, cap_trst = '0;
  logic          prev_tclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: records TMS/TDI/TRST_N at each TCK rise, drives TDO from the pattern,
  // and scores each done pulse against the oldest queued prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      tck_cnt = 0; cap_tms = '0; cap_tdi = '0; cap_trst = '0; prev_tclk = 1'b0;
    end else begin
      if (tclk && !prev_tclk && tck_cnt < 64) begin
        cap_tms[tck_cnt]  = tms;
        cap_tdi[tck_cnt]  = tdi;
        cap_trst[tck_cnt] = trst_n;
        tck_cnt++;
      end
      prev_tclk = tclk;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(e.due));
          checkOutput("tck_count", 64'(tck_cnt), 64'(e.ntck));
          checkOutput("tms_seq", cap_tms, e.tms);
          checkOutput("tdi_seq", cap_tdi, e.tdi);
          checkOutput("trst_seq", cap_trst, e.trst);
          checkOutput("data_out", 64'(data_out), 64'(e.dout));
          checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        end
        tck_cnt = 0; cap_tms = '0; cap_tdi = '0; cap_trst = '0;
      end
      tdo = (sb.size() != 0 && tck_cnt < 64) ? sb[0].pat[tck_cnt] : 1'b0;
    end
  end

  // Reference model: builds the expected TCK-by-TCK behaviour from the command rules.
  task automatic predict(input logic [1:0] c, input int len, input logic [DW-1:0] d,
                         output exp_t e);
    exp_t x;
    int n;
    int first;
    x.pat = {$urandom, $urandom};
    x.tms = '0; x.tdi = '0; x.trst = '0;
    n = 0;
    if (c == 2'b10) begin
      for (int i = 0; i < 6; i++) begin
        x.tms[n] = (i < 5); x.trst[n] = (i == 5); n++;
      end
      tlr_m = 1'b0;
    end else if (c[1] == 1'b0 && len >= 1 && len <= DW) begin
      if (tlr_m) begin x.tms[n] = 1'b0; x.trst[n] = 1'b1; n++; end
      x.tms[n] = 1'b1; x.trst[n] = 1'b1; n++;
      if (c == 2'b01) begin x.tms[n] = 1'b1; x.trst[n] = 1'b1; n++; end
      for (int i = 0; i < 2; i++) begin x.tms[n] = 1'b0; x.trst[n] = 1'b1; n++; end
      first = n;
      for (int i = 0; i < len; i++) begin
        x.tms[n] = (i == len - 1); x.tdi[n] = d[i]; x.trst[n] = 1'b1; n++;
      end
      x.tms[n] = 1'b1; x.trst[n] = 1'b1; n++;
      x.tms[n] = 1'b0; x.trst[n] = 1'b1; n++;
      dout_m = '0;
      for (int i = 0; i < len; i++) dout_m[i] = x.pat[first + i];
      tlr_m = 1'b0;
    end
    x.ntck = n;
    x.dout = dout_m;
    x.due  = cyc + 1 + ((n == 0) ? 1 : 2 * DIVCNT * n);
    e = x;
  endtask

  task automatic issueCmd(input logic [1:0] c, input int len, input logic [DW-1:0] d);
    exp_t e;
    predict(c, len, d, e);
    sb.push_back(e);
    cmd = c; shift_len = len[LW-1:0]; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_done", {63'd0, done}, 64'd0);
    checkOutput("idle_tclk", {63'd0, tclk}, 64'd0);
    checkOutput("idle_tdi", {63'd0, tdi}, 64'd0);
    checkOutput("idle_tms", {63'd0, tms}, {63'd0, tlr_m});
    checkOutput("idle_data_out", 64'(data_out), 64'(dout_m));
  endtask

  task automatic applyStimulus(input logic [1:0] c, input int len, input logic [DW-1:0] d);
    issueCmd(c, len, d);
    waitIdle();
  endtask

  initial begin
    logic [1:0]    c;
    int            len;
    int            r;
    logic [DW-1:0] d;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    checkOutput("rst_tclk", {63'd0, tclk}, 64'd0);
    checkOutput("rst_tms", {63'd0, tms}, 64'd1);
    checkOutput("rst_tdi", {63'd0, tdi}, 64'd0);
    checkOutput("rst_trst_n", {63'd0, trst_n}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("release_trst_n", {63'd0, trst_n}, 64'd1);
    checkOutput("release_tms", {63'd0, tms}, 64'd1);

    $display("[TB] scan straight out of reset (PRE expected)");
    applyStimulus(2'b00, 1, $urandom);
    $display("[TB] TAP reset command");
    applyStimulus(2'b10, 0, '0);
    applyStimulus(2'b01, 4, 32'h3);
    applyStimulus(2'b00, 32, $urandom);

    $display("[TB] no-op commands");
    applyStimulus(2'b00, 0, $urandom);
    applyStimulus(2'b01, 33, $urandom);
    applyStimulus(2'b11, 8, $urandom);
    applyStimulus(2'b00, 63, $urandom);

    $display("[TB] randomized commands");
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 7) == 0)
        len = $urandom_range(0, 1) ? 0 : $urandom_range(33, 63);
      else
        len = $urandom_range(1, DW);
      d = $urandom;
      applyStimulus(c, len, d);
    end

    $display("[TB] start while busy is ignored");
    d = $urandom;
    issueCmd(2'b00, 32, d);
    repeat (20) @(negedge clk);
    checkOutput("busy_mid_scan", {63'd0, busy}, 64'd1);
    cmd = 2'b01; shift_len = 6'd5; data_in = ~d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] reset in the middle of a scan");
    issueCmd(2'b00, 32, $urandom);
    for (int i = 0; i < 2000 && tck_cnt < 10; i++) @(negedge clk);
    checkOutput("reached_tck10", 64'(tck_cnt), 64'd10);
    reset_n = 1'b0;
    sb.delete();
    tlr_m = 1'b1;
    dout_m = '0;
    @(negedge clk);
    checkOutput("midrst_tclk", {63'd0, tclk}, 64'd0);
    checkOutput("midrst_tms", {63'd0, tms}, 64'd1);
    checkOutput("midrst_trst_n", {63'd0, trst_n}, 64'd0);
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_trst_n", {63'd0, trst_n}, 64'd1);
    applyStimulus(2'b00, 8, $urandom);
    applyStimulus(2'b01, 4, $urandom);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
